md_result_reader: RTL
=====================

MD_RESULT_READER -- requirements
Module: md_result_reader

Interface
REQ-001 Parameter RD_LATENCY, default 1, regfile read latency in cycles after rd_en; legal range 1..3.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  host requests readback of one atom.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_addr  input  6  atom index to read.
REQ-007 num_atoms  input  6  count of valid atoms; legal indices are 0..num_atoms-1.
REQ-008 rd_en  output  1  regfile read strobe.
REQ-009 rd_addr  output  6  regfile read address.
REQ-010 rd_x, rd_y, rd_z  input  32 each  regfile read data, valid RD_LATENCY cycles after rd_en.
REQ-011 byte_out  output  8  serialized frame byte.
REQ-012 byte_valid  output  1  byte_out holds a valid byte.
REQ-013 byte_ready  input  1  consumer accepts byte_out.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err  output  1  one-cycle pulse on an out-of-range request.

Function
REQ-016 States: IDLE, FETCH, WAIT, SEND.
REQ-017 IDLE: req_ready=1; handshake = req_valid && req_ready.
REQ-018 Handshake with req_addr >= num_atoms: err=1 next cycle, stay IDLE, no rd_en; num_atoms=0 rejects all requests.
REQ-019 Handshake with legal addr: latch addr, go FETCH.
REQ-020 FETCH: rd_en=1 for exactly one cycle, rd_addr=latched addr; go WAIT.
REQ-021 WAIT: down-counter loaded with RD_LATENCY; sample {rd_z,rd_y,rd_x} into a 96-bit buffer exactly RD_LATENCY cycles after the rd_en cycle; go SEND.
REQ-022 rd_addr holds the latched addr from FETCH until return to IDLE; 0 in IDLE.
REQ-023 Frame = 14 bytes: B0 = {2'b11, addr}; B1..B4 = x LSB first; B5..B8 = y LSB first; B9..B12 = z LSB first; B13 = XOR of B0..B12.
REQ-024 SEND: byte_valid=1; byte index 0..13 advances only on byte_valid && byte_ready.
REQ-025 byte_out and byte_valid stay stable while byte_valid && !byte_ready (no drop, no skip).
REQ-026 Acceptance of B13 -> IDLE in the next cycle; byte_valid=0 there; a new request is accepted no earlier than that IDLE cycle.
REQ-027 req_ready=0 in FETCH/WAIT/SEND; req_valid is ignored there.
REQ-028 Minimum request-to-B0-valid latency = RD_LATENCY+2 cycles; with byte_ready held high, frame takes 14 consecutive cycles.
REQ-029 Checksum accumulates as a running XOR over bytes as they are presented.
REQ-030 Regfile data changes after the sample cycle do not affect the frame.

Reset
REQ-031 rst_n low at a clock edge -> IDLE and clears the buffer, checksum, byte index and counter.
REQ-032 Reset values: req_ready=1 after release, rd_en=0, rd_addr=0, byte_out=0, byte_valid=0, busy=0, err=0.
REQ-033 Reset mid-frame aborts the frame; no remaining bytes are emitted after release.

Structure
REQ-034 Shared package md_pkg holds: the state enum, FRAME_LEN=14, HDR_TAG=2'b11, ATOM_ADDR_W=6, COORD_W=32.
REQ-035 One sub-module md_frame_serializer (96-bit buffer, byte index, checksum, valid/ready output); the FSM and regfile read control stay in the top.

Verification
REQ-036 RD_LATENCY=1, num_atoms=10, req addr 3, x=0x11223344, y=0x0, z=0xAABBCCDD, byte_ready=1 -> bytes C3,44,33,22,11,00,00,00,00,DD,CC,BB,AA,checksum=C3^44^33^22^11^DD^CC^BB^AA; exactly one rd_en with rd_addr=3.
REQ-037 Request addr 10 with num_atoms=10 -> err pulses 1 cycle; no rd_en; req_ready stays 1.
REQ-038 byte_ready toggled randomly during a frame -> byte_out stable while stalled; 14 bytes, in order, none duplicated.
REQ-039 RD_LATENCY=3 -> data sampled exactly 3 cycles after rd_en; regfile data changed one cycle later does not appear in the frame.
REQ-040 rst_n low during byte 6 -> byte_valid=0 and busy=0 after the reset edge; next request yields a complete, correct frame.
REQ-041 Back-to-back requests (req_valid held high, addrs 0 then 1) -> second accepted only in the IDLE cycle after B13 acceptance; frames do not overlap.

Source files
------------

// File: rtl/md_result_reader_pkg.sv
// Shared types and constants for the atom result readback path.
package md_pkg;

  localparam int         FRAME_LEN   = 14;
  localparam logic [1:0] HDR_TAG     = 2'b11;
  localparam int         ATOM_ADDR_W = 6;
  localparam int         COORD_W     = 32;
  localparam int         BUF_W       = 3 * COORD_W;
  localparam int         DATA_BYTES  = BUF_W / 8;
  localparam int         IDX_W       = 4;
  localparam int         CNT_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND
  } md_state_e;

  function automatic logic [7:0] hdr_byte(input logic [ATOM_ADDR_W-1:0] addr);
    return {HDR_TAG, addr};
  endfunction

endpackage

// File: rtl/md_result_reader_if.sv
// Host request, regfile read and byte-stream signals of the result reader.
interface md_result_reader_if;

  logic                            req_valid;
  logic                            req_ready;
  logic [md_pkg::ATOM_ADDR_W-1:0]  req_addr;
  logic [md_pkg::ATOM_ADDR_W-1:0]  num_atoms;
  logic                            rd_en;
  logic [md_pkg::ATOM_ADDR_W-1:0]  rd_addr;
  logic [md_pkg::COORD_W-1:0]      rd_x;
  logic [md_pkg::COORD_W-1:0]      rd_y;
  logic [md_pkg::COORD_W-1:0]      rd_z;
  logic [7:0]                      byte_out;
  logic                            byte_valid;
  logic                            byte_ready;
  logic                            busy;
  logic                            err;

  modport master (
    output req_valid, req_addr, num_atoms, rd_x, rd_y, rd_z, byte_ready,
    input  req_ready, rd_en, rd_addr, byte_out, byte_valid, busy, err
  );

  modport slave (
    input  req_valid, req_addr, num_atoms, rd_x, rd_y, rd_z, byte_ready,
    output req_ready, rd_en, rd_addr, byte_out, byte_valid, busy, err
  );

endinterface

// File: rtl/md_frame_serializer.sv
// Holds one sampled atom and streams it as a 14-byte frame with trailing XOR checksum.
module md_frame_serializer
  import md_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [ATOM_ADDR_W-1:0] addr_i,
  input  logic [BUF_W-1:0]       data_i,
  input  logic                   ready_i,
  output logic [7:0]             byte_o,
  output logic                   valid_o,
  output logic                   done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [DATA_BYTES-1:0][7:0] buf_q, buf_d;
  logic [7:0]                 hdr_q, hdr_d;
  logic [7:0]                 csum_q, csum_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       active_q, active_d;
  logic [7:0]                 cur_byte;
  logic                       accept;

  // Byte 0 is the header, the last byte the checksum, everything between comes from the buffer.
  always_comb begin
    cur_byte = 8'h00;
    if (idx_q == '0) begin
      cur_byte = hdr_q;
    end else if (idx_q == LAST_IDX) begin
      cur_byte = csum_q;
    end else begin
      cur_byte = buf_q[idx_q - 4'd1];
    end
  end

  assign accept = active_q && ready_i;

  always_comb begin
    buf_d    = buf_q;
    hdr_d    = hdr_q;
    csum_d   = csum_q;
    idx_d    = idx_q;
    active_d = active_q;
    done_o   = 1'b0;
    if (load_i) begin
      buf_d    = data_i;
      hdr_d    = hdr_byte(addr_i);
      csum_d   = '0;
      idx_d    = '0;
      active_d = 1'b1;
    end else if (accept) begin
      if (idx_q == LAST_IDX) begin
        active_d = 1'b0;
        idx_d    = '0;
        csum_d   = '0;
        done_o   = 1'b1;
      end else begin
        idx_d  = idx_q + 4'd1;
        csum_d = csum_q ^ cur_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q    <= '0;
      hdr_q    <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      hdr_q    <= hdr_d;
      csum_q   <= csum_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  assign valid_o = active_q;
  assign byte_o  = active_q ? cur_byte : 8'h00;

endmodule

// File: rtl/md_result_reader.sv
// Reads one atom's coordinates from the regfile on request and emits them as a byte frame.
//   state    | meaning
//   ST_IDLE  | ready for a request; range-checks the address
//   ST_FETCH | one-cycle regfile read strobe
//   ST_WAIT  | down-count the regfile latency, sample data on terminal count
//   ST_SEND  | serializer streams the frame until the checksum byte is taken
module md_result_reader
  import md_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  md_result_reader_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = RD_LATENCY[CNT_W-1:0];

  md_state_e              state_q, state_d;
  logic [ATOM_ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   load;
  logic                   frame_done;
  logic [7:0]             ser_byte;
  logic                   ser_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_addr >= bus.num_atoms) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bus.req_addr;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        cnt_d   = CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Terminal count lands exactly RD_LATENCY cycles after the strobe.
        if (cnt_q == 2'd1) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_SEND: begin
        if (frame_done) begin
          addr_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        addr_d  = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  md_frame_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .addr_i  (addr_q),
    .data_i  ({bus.rd_z, bus.rd_y, bus.rd_x}),
    .ready_i (bus.byte_ready),
    .byte_o  (ser_byte),
    .valid_o (ser_valid),
    .done_o  (frame_done)
  );

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.rd_en      = (state_q == ST_FETCH);
  assign bus.rd_addr    = addr_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.err        = err_q;
  assign bus.byte_out   = ser_byte;
  assign bus.byte_valid = ser_valid;

endmodule
